// File: rtl/stage_decode.sv
// Decode stage: registers the fetch output into stage_id and tracks in-flight
// destination registers in a shift-register scoreboard. A read-after-write
// hazard inserts bubbles and holds fetch through stall until the producer has
// aged out of the scoreboard.

package stage_decode_pkg;
  typedef struct packed {
    logic [31:0] ip;
    logic [31:0] instruction;
    logic [7:0]  operation;
    logic [7:0]  rd;
    logic [7:0]  r1;
    logic [7:0]  r2;
  } t_stage;
endpackage

module stage_decode
  import stage_decode_pkg::*;
#(
  parameter int         DEPTH  = 3,
  parameter logic [7:0] NOP_OP = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  t_stage      stage_if,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall,
  output t_stage      stage_id,
  output logic        id_valid,
  output logic [31:0] bubble_count
);

  // A bubble carries only the NOP opcode; every other field is zero.
  localparam t_stage BUBBLE = '{ip: 32'd0, instruction: 32'd0, operation: NOP_OP,
                                rd: 8'd0, r1: 8'd0, r2: 8'd0};

  t_stage                  stage_id_reg;
  logic                    id_valid_reg;
  logic [31:0]             bubble_count_reg;
  logic [DEPTH-1:0]        sb_valid_reg;
  logic [DEPTH-1:0][7:0]   sb_rd_reg;

  logic [DEPTH-1:0]        sb_valid_next;
  logic [DEPTH-1:0][7:0]   sb_rd_next;
  logic [DEPTH-1:0]        r1_match;
  logic [DEPTH-1:0]        r2_match;

  logic is_nop;
  logic writes;
  logic hazard;
  logic accept;    // stage_if moves into stage_id this edge
  logic shift_en;  // scoreboard ages this edge

  assign is_nop   = (stage_if.operation == NOP_OP);
  assign writes   = !is_nop && !stage_if.operation[7];
  assign hazard   = !is_nop &&
                    (((stage_if.r1 != 8'd0) && (|r1_match)) ||
                     ((stage_if.r2 != 8'd0) && (|r2_match)));
  assign shift_en = flush || !stall_in;
  assign accept   = !flush && !stall_in && !hazard;
  assign stall    = hazard || stall_in;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sb
      assign r1_match[gi] = sb_valid_reg[gi] && (sb_rd_reg[gi] == stage_if.r1);
      assign r2_match[gi] = sb_valid_reg[gi] && (sb_rd_reg[gi] == stage_if.r2);
      if (gi == 0) begin : g_head
        // Only an accepted writer of a non-zero register enters the scoreboard.
        assign sb_valid_next[gi] = accept && writes && (stage_if.rd != 8'd0);
        assign sb_rd_next[gi]    = accept ? stage_if.rd : 8'd0;
      end else begin : g_tail
        assign sb_valid_next[gi] = sb_valid_reg[gi-1];
        assign sb_rd_next[gi]    = sb_rd_reg[gi-1];
      end
    end
  endgenerate

  // Scoreboard ages every cycle except when downstream holds the pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_valid_reg <= '0;
      sb_rd_reg    <= '0;
    end else if (shift_en) begin
      sb_valid_reg <= sb_valid_next;
      sb_rd_reg    <= sb_rd_next;
    end
  end

  // Decode register: flush beats stall_in, stall_in beats hazard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_id_reg <= BUBBLE;
      id_valid_reg <= 1'b0;
    end else if (flush || (!stall_in && hazard)) begin
      stage_id_reg <= BUBBLE;
      id_valid_reg <= 1'b0;
    end else if (!stall_in) begin
      stage_id_reg <= stage_if;
      id_valid_reg <= !is_nop;
    end
  end

  // Hazard bubble counter, saturating; flush bubbles are not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_count_reg <= 32'd0;
    end else if (!flush && !stall_in && hazard && (bubble_count_reg != 32'hFFFF_FFFF)) begin
      bubble_count_reg <= bubble_count_reg + 32'd1;
    end
  end

  assign stage_id     = stage_id_reg;
  assign id_valid     = id_valid_reg;
  assign bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_stage_decode.sv
// Directed bench for stage_decode (DEPTH = 3): independent stream, RAW
// bubbles, register 0 and store-class handling, stall_in hold, flush, and an
// asynchronous reset between clock edges.

module tb_stage_decode;
  import stage_decode_pkg::*;

  logic        clock;
  logic        reset;
  t_stage      stage_if;
  logic        stall_in;
  logic        flush;
  logic        stall;
  t_stage      stage_id;
  logic        id_valid;
  logic [31:0] bubble_count;

  int n_cmp = 0;
  int n_bad = 0;

  stage_decode #(.DEPTH(3), .NOP_OP(8'h00)) dut (
    .clock        (clock),
    .reset        (reset),
    .stage_if     (stage_if),
    .stall_in     (stall_in),
    .flush        (flush),
    .stall        (stall),
    .stage_id     (stage_id),
    .id_valid     (id_valid),
    .bubble_count (bubble_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  function automatic t_stage mk(input logic [31:0] ip, input logic [7:0] op,
                                input logic [7:0] rd, input logic [7:0] r1, input logic [7:0] r2);
    t_stage s;
    s.ip          = ip;
    s.instruction = {op, rd, r1, r2};
    s.operation   = op;
    s.rd          = rd;
    s.r1          = r1;
    s.r2          = r2;
    return s;
  endfunction

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a new fetch word and let the combinational stall settle.
  task automatic drive(input t_stage s);
    stage_if = s;
    #1;
  endtask

  task automatic drain();
    drive(mk(32'd0, 8'h00, 8'd0, 8'd0, 8'd0));
    repeat (3) tick();
  endtask

  initial begin
    reset    = 1'b1;
    stall_in = 1'b0;
    flush    = 1'b0;
    stage_if = mk(32'd0, 8'h00, 8'd0, 8'd0, 8'd0);
    #1;
    chk("rst_op", {24'd0, stage_id.operation}, 32'h00);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_bcnt", bubble_count, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #12 reset = 1'b0;
    tick();

    // Independent stream.
    drive(mk(32'h100, 8'h01, 8'd3, 8'd1, 8'd2));
    chk("ind_stall0", {31'd0, stall}, 32'd0);
    tick();
    chk("ind_rd0", {24'd0, stage_id.rd}, 32'd3);
    chk("ind_ip0", stage_id.ip, 32'h100);
    chk("ind_valid0", {31'd0, id_valid}, 32'd1);
    drive(mk(32'h104, 8'h01, 8'd4, 8'd5, 8'd6));
    chk("ind_stall1", {31'd0, stall}, 32'd0);
    tick();
    chk("ind_rd1", {24'd0, stage_id.rd}, 32'd4);
    chk("ind_instr1", stage_id.instruction, 32'h01040506);
    chk("ind_bcnt", bubble_count, 32'd0);
    drain();

    // Back-to-back RAW: three bubbles, then the consumer enters.
    drive(mk(32'h200, 8'h01, 8'd3, 8'd1, 8'd2));
    tick();
    drive(mk(32'h204, 8'h01, 8'd7, 8'd3, 8'd0));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("raw_stall%0d", i), {31'd0, stall}, 32'd1);
      tick();
      chk($sformatf("raw_valid%0d", i), {31'd0, id_valid}, 32'd0);
      chk($sformatf("raw_bcnt%0d", i), bubble_count, i + 1);
    end
    chk("raw_stall_end", {31'd0, stall}, 32'd0);
    tick();
    chk("raw_rd", {24'd0, stage_id.rd}, 32'd7);
    chk("raw_ip", stage_id.ip, 32'h204);
    chk("raw_valid", {31'd0, id_valid}, 32'd1);
    drain();

    // Register 0 and store-class writers never create hazards.
    drive(mk(32'h300, 8'h01, 8'd0, 8'd1, 8'd2));
    tick();
    drive(mk(32'h304, 8'h01, 8'd8, 8'd0, 8'd0));
    chk("r0_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(mk(32'h308, 8'h80, 8'd5, 8'd9, 8'd9));
    chk("st_stall0", {31'd0, stall}, 32'd0);
    tick();
    drive(mk(32'h30C, 8'h01, 8'd10, 8'd5, 8'd5));
    chk("st_stall1", {31'd0, stall}, 32'd0);
    tick();
    chk("st_rd", {24'd0, stage_id.rd}, 32'd10);
    chk("st_bcnt", bubble_count, 32'd3);
    drain();

    // stall_in in the middle of a RAW hazard.
    drive(mk(32'h400, 8'h01, 8'd3, 8'd1, 8'd2));
    tick();
    drive(mk(32'h404, 8'h01, 8'd7, 8'd3, 8'd3));
    chk("si_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("si_bcnt0", bubble_count, 32'd4);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("si_hold_bcnt%0d", i), bubble_count, 32'd4);
      chk($sformatf("si_hold_valid%0d", i), {31'd0, id_valid}, 32'd0);
    end
    stall_in = 1'b0;
    #1;
    chk("si_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("si_stall2", {31'd0, stall}, 32'd1);
    tick();
    chk("si_stall3", {31'd0, stall}, 32'd0);
    chk("si_bcnt", bubble_count, 32'd6);
    tick();
    chk("si_rd", {24'd0, stage_id.rd}, 32'd7);
    // Hold a real instruction in stage_id.
    drive(mk(32'h408, 8'h01, 8'd11, 8'd1, 8'd1));
    stall_in = 1'b1;
    #1;
    chk("si_stall_out", {31'd0, stall}, 32'd1);
    tick();
    chk("si_hold_rd", {24'd0, stage_id.rd}, 32'd7);
    chk("si_hold_ip", stage_id.ip, 32'h404);
    chk("si_hold_v", {31'd0, id_valid}, 32'd1);
    stall_in = 1'b0;
    drain();

    // Flush while a hazard is pending: no count, scoreboard still shifts.
    drive(mk(32'h500, 8'h01, 8'd3, 8'd1, 8'd2));
    tick();
    drive(mk(32'h504, 8'h01, 8'd7, 8'd3, 8'd0));
    chk("fl_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_op", {24'd0, stage_id.operation}, 32'h00);
    chk("fl_bcnt", bubble_count, 32'd6);
    drive(mk(32'h508, 8'h01, 8'd9, 8'd3, 8'd4));
    chk("fl_next_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("fl_next_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("fl_next_stall2", {31'd0, stall}, 32'd0);
    chk("fl_next_bcnt", bubble_count, 32'd8);
    tick();
    chk("fl_next_rd", {24'd0, stage_id.rd}, 32'd9);
    // Flush overrides stall_in.
    stall_in = 1'b1;
    flush    = 1'b1;
    tick();
    chk("fl_over_si", {31'd0, id_valid}, 32'd0);
    stall_in = 1'b0;
    flush    = 1'b0;
    drain();

    // Asynchronous reset between edges while a hazard is stalling.
    drive(mk(32'h600, 8'h01, 8'd3, 8'd1, 8'd2));
    tick();
    drive(mk(32'h604, 8'h01, 8'd7, 8'd3, 8'd0));
    tick();
    #1 reset = 1'b1;
    #1;
    chk("mrst_op", {24'd0, stage_id.operation}, 32'h00);
    chk("mrst_ip", stage_id.ip, 32'd0);
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_bcnt", bubble_count, 32'd0);
    #1 reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
